// File: rtl/float_mul_pkg.sv
// ----------------------------------------------------------------------------
// float_mul_pkg : shared types for the FP multiply issue/writeback controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package float_mul_pkg;

  localparam int C_REG_AW = 5;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_e;

  // Destination tag travelling alongside one pipe stage
  typedef struct packed {
    logic                valid;
    logic [C_REG_AW-1:0] tag;
  } tag_slot_t;

endpackage

`default_nettype wire

// File: rtl/float_mul_hazard.sv
// ----------------------------------------------------------------------------
// float_mul_hazard : RAW tag compare against the a/n stages (FLOAT_MUL_FWD_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module float_mul_hazard
  import float_mul_pkg::*;
(
  input  logic                i_valid,
  input  logic [C_REG_AW-1:0] i_fs,
  input  logic [C_REG_AW-1:0] i_ft,
  input  tag_slot_t           i_slot_a,
  input  tag_slot_t           i_slot_n,
  output logic                o_stall,
  output logic                o_fwd_a,
  output logic                o_fwd_b
);

  logic w_a_fs, w_a_ft, w_n_fs, w_n_ft;

  assign w_a_fs = i_valid & i_slot_a.valid & (i_fs == i_slot_a.tag);
  assign w_a_ft = i_valid & i_slot_a.valid & (i_ft == i_slot_a.tag);
  assign w_n_fs = i_valid & i_slot_n.valid & (i_fs == i_slot_n.tag);
  assign w_n_ft = i_valid & i_slot_n.valid & (i_ft == i_slot_n.tag);

`ifdef FLOAT_MUL_FWD_EN
  // The n-stage result is on the bypass mux this cycle; only the a stage is too young
  assign o_stall = w_a_fs | w_a_ft;
  assign o_fwd_a = w_n_fs;
  assign o_fwd_b = w_n_ft;
`else
  assign o_stall = w_a_fs | w_a_ft | w_n_fs | w_n_ft;
  assign o_fwd_a = 1'b0;
  assign o_fwd_b = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/float_mul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// float_mul_issue_ctrl : issue, tag tracking and regfile write for the FP mul pipe
// Optional n-stage bypass: FLOAT_MUL_FWD_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module float_mul_issue_ctrl
  import float_mul_pkg::*;
#(
  parameter int REG_AW = C_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_fs,
  input  logic [REG_AW-1:0] id_ft,
  input  logic [REG_AW-1:0] id_fd,
  input  logic [1:0]        id_rm,
  input  logic              stall_ext,
  output logic              pipe_en,
  output logic [1:0]        pipe_rm,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_fd,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  tag_slot_t        r_slot_a;
  tag_slot_t        r_slot_n;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hazard;
  logic             w_pipe_en;
  logic             w_ready;

  float_mul_hazard u_hazard (
    .i_valid  (id_valid),
    .i_fs     (id_fs),
    .i_ft     (id_ft),
    .i_slot_a (r_slot_a),
    .i_slot_n (r_slot_n),
    .o_stall  (w_hazard),
    .o_fwd_a  (fwd_a),
    .o_fwd_b  (fwd_b)
  );

  assign w_pipe_en = rst_n & ~stall_ext;
  assign w_ready   = w_pipe_en & ~w_hazard;

  // Tags move in lockstep with the m2a/a2n data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_a <= '0;
      r_slot_n <= '0;
    end else if (w_pipe_en) begin
      r_slot_a <= '{valid: id_valid & w_ready, tag: id_fd};
      r_slot_n <= r_slot_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (id_valid && !w_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
    end
  end

  assign id_ready  = w_ready;
  assign pipe_en   = w_pipe_en;
  assign pipe_rm   = id_rm;
  // Qualifying with pipe_en keeps a frozen n-stage op from writing more than once
  assign wb_we     = r_slot_n.valid & w_pipe_en;
  assign wb_fd     = r_slot_n.tag;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
